// File: rtl/trojan_resp_capture.sv
// Response capture for exhaustive-stimulus sweeps: FWFT readout FIFO
// plus MISR compaction and a golden-signature verdict.
module trojan_resp_capture #(
    parameter int              N_IN   = 4,
    parameter int              DEPTH  = 16,
    parameter int              MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY = 16'h1021
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       cap_valid,
    output logic                       cap_ready,
    input  logic [N_IN-1:0]            cap_pattern,
    input  logic                       cap_resp,
    input  logic                       cap_last,
    input  logic [MISR_W-1:0]          golden_sig,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [N_IN:0]              rd_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [N_IN:0]              beat_count,
    output logic [MISR_W-1:0]          signature,
    output logic                       done,
    output logic                       mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = N_IN + 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [DW-1:0]   beat_q, beat_d;
    logic [MISR_W-1:0] sig_q, sig_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic            accept;
    logic            pop;
    logic [DW-1:0]   wdata;

    assign wdata     = {cap_pattern, cap_resp};
    assign cap_ready = (state_q == CAPTURE) && (count_q != FULL) && !start;
    assign accept    = cap_valid && cap_ready;
    assign pop       = rd_en && (count_q != '0) && !start;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        sig_d    = sig_q;
        done_d   = done_q;
        mis_d    = mis_q;
        if (start) begin
            // A new session discards everything from the previous one
            state_d  = CAPTURE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            beat_d   = '0;
            sig_d    = '0;
            done_d   = 1'b0;
            mis_d    = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (beat_q != '1)
                    beat_d = beat_q + 1'b1;
                sig_d = {sig_q[MISR_W-2:0], 1'b0}
                      ^ (sig_q[MISR_W-1] ? POLY : '0)
                      ^ MISR_W'(wdata);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);
            case (state_q)
                CAPTURE: if (accept && cap_last) state_d = COMPARE;
                COMPARE: begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    mis_d   = (sig_q != golden_sig);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            sig_q    <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            sig_q    <= sig_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
        end
    end

    always_ff @(posedge CK) begin
        if (accept)
            mem_q[wr_ptr_q] <= wdata;
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign beat_count = beat_q;
    assign signature  = sig_q;
    assign done       = done_q;
    assign mismatch   = mis_q;

endmodule

// File: tb/tb_trojan_resp_capture.sv
// Randomised bench for trojan_resp_capture against a queue-based
// behavioural model of the capture session.
module tb_trojan_resp_capture;

    logic        CK = 0;
    logic        reset = 0;
    logic        start = 0;
    logic        cap_valid = 0;
    logic        cap_ready;
    logic [3:0]  cap_pattern = 0;
    logic        cap_resp = 0;
    logic        cap_last = 0;
    logic [15:0] golden_sig = 0;
    logic        rd_en = 0;
    logic        rd_valid;
    logic [4:0]  rd_data;
    logic [4:0]  fifo_count;
    logic [4:0]  beat_count;
    logic [15:0] signature;
    logic        done;
    logic        mismatch;

    int errors = 0;
    int checks = 0;

    // model: 0 idle, 1 capturing, 2 comparing, 3 finished
    int          m_ph = 0;
    logic [4:0]  m_q[$];
    logic [15:0] m_sig = 0;
    int          m_beats = 0;
    logic        m_done = 0;
    logic        m_mis = 0;

    trojan_resp_capture dut (
        .CK(CK), .reset(reset), .start(start),
        .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_pattern(cap_pattern), .cap_resp(cap_resp),
        .cap_last(cap_last), .golden_sig(golden_sig),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_count(fifo_count), .beat_count(beat_count),
        .signature(signature), .done(done), .mismatch(mismatch)
    );

    always #5 CK = ~CK;

    // signature times x modulo x^16+x^12+x^5+1, plus the new beat
    function automatic logic [15:0] misr(logic [15:0] s, logic [4:0] d);
        int x;
        x = int'(s) * 2;
        if (x >= 65536) x = x ^ 32'h11021;
        return 16'(x) ^ {11'd0, d};
    endfunction

    function automatic logic [4:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 5'd0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_q.delete(); m_sig = 0;
        m_beats = 0; m_done = 0; m_mis = 0;
    endtask

    // one clock: drive, sample ready, advance model, release strobes
    task automatic cyc(input bit st, input bit v, input logic [3:0] p,
                       input bit r, input bit l, input bit rd,
                       output bit exp_rdy, output bit got_rdy);
        start = st; cap_valid = v; cap_pattern = p;
        cap_resp = r; cap_last = l; rd_en = rd;
        #1;
        got_rdy = cap_ready;
        exp_rdy = !st && m_ph == 1 && m_q.size() < 16;
        @(posedge CK);
        if (st) begin
            model_reset();
            m_ph = 1;
        end else begin
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (m_ph == 2) begin
                m_done = 1;
                m_mis = (m_sig != golden_sig);
                m_ph = 3;
            end else if (v && exp_rdy) begin
                m_q.push_back({p, r});
                m_sig = misr(m_sig, {p, r});
                if (m_beats < 31) m_beats++;
                if (l) m_ph = 2;
            end
        end
        #1;
        start = 0; cap_valid = 0; cap_last = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({cap_ready, rd_valid, rd_data, fifo_count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_fifo: got %b want 0",
                     {cap_ready, rd_valid, rd_data, fifo_count});
        end
        checks++;
        if ({beat_count, signature, done, mismatch} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0",
                     {beat_count, signature, done, mismatch});
        end
        @(posedge CK); @(posedge CK); #1;
        reset = 1;
    endtask

    task automatic test_basic(input logic [15:0] gold, input bit exp_mis);
        bit e, g;
        golden_sig = gold;
        cyc(1, 0, 0, 0, 0, 0, e, g);
        cyc(0, 1, 4'b0001, 1, 0, 0, e, g);
        checks++;
        if (g !== 1'b1 || signature !== 16'h0003) begin
            errors++;
            $display("FAIL basic_beat1: rdy %b sig %h want 1 0003", g, signature);
        end
        cyc(0, 1, 4'b0010, 0, 1, 0, e, g);
        checks++;
        if (signature !== 16'h0002 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat2: sig %h done %b want 0002 0", signature, done);
        end
        cyc(0, 0, 0, 0, 0, 0, e, g);
        checks++;
        if (done !== 1'b1 || mismatch !== exp_mis) begin
            errors++;
            $display("FAIL basic_verdict: done %b mis %b want 1 %b", done, mismatch, exp_mis);
        end
    endtask

    task automatic test_readout();
        bit e, g;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 5'b00011) begin
            errors++;
            $display("FAIL rd_first: got %b %b want 1 00011", rd_valid, rd_data);
        end
        cyc(0, 0, 0, 0, 0, 1, e, g);
        checks++;
        if (rd_data !== 5'b00100) begin
            errors++;
            $display("FAIL rd_second: got %b want 00100", rd_data);
        end
        cyc(0, 0, 0, 0, 0, 1, e, g);
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL rd_empty: got %b %0d want 0 0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_restart();
        bit e, g;
        cyc(1, 0, 0, 0, 0, 0, e, g);
        checks++;
        if (done !== 1'b0 || signature !== 16'h0 || fifo_count !== 5'd0
            || beat_count !== 5'd0) begin
            errors++;
            $display("FAIL restart: done %b sig %h cnt %0d beats %0d want 0",
                     done, signature, fifo_count, beat_count);
        end
    endtask

    task automatic test_full();
        bit e, g;
        cyc(1, 0, 0, 0, 0, 0, e, g);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 4'(i), 1'($urandom % 2), 0, 0, e, g);
            checks++;
            if (g !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d: rdy %b want 1", i, g);
            end
        end
        cyc(0, 1, 4'hA, 1, 0, 1, e, g);
        checks++;
        if (g !== 1'b0 || e !== 1'b0) begin
            errors++;
            $display("FAIL full_block: rdy %b want 0", g);
        end
        checks++;
        if (fifo_count !== 5'd15 || rd_data !== m_head()) begin
            errors++;
            $display("FAIL full_pop: cnt %0d data %b want 15 %b",
                     fifo_count, rd_data, m_head());
        end
        cyc(0, 1, 4'hB, 0, 0, 0, e, g);
        checks++;
        if (g !== 1'b1 || fifo_count !== 5'd16 || beat_count !== 5'(m_beats)) begin
            errors++;
            $display("FAIL full_refill: rdy %b cnt %0d beats %0d want 1 16 %0d",
                     g, fifo_count, beat_count, m_beats);
        end
    endtask

    task automatic test_start_collision();
        bit e, g;
        cyc(1, 1, 4'b0101, 1, 0, 0, e, g);
        checks++;
        if (g !== 1'b0 || beat_count !== 5'd0 || fifo_count !== 5'd0
            || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_wins: rdy %b beats %0d cnt %0d want 0 0 0",
                     g, beat_count, fifo_count);
        end
    endtask

    task automatic test_push_pop();
        bit e, g;
        cyc(0, 0, 0, 0, 0, 1, e, g);
        checks++;
        if (fifo_count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 5'd0) begin
            errors++;
            $display("FAIL empty_read: cnt %0d vld %b data %b want 0 0 0",
                     fifo_count, rd_valid, rd_data);
        end
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 4'($urandom), 1'($urandom % 2), 0, 0, e, g);
        cyc(0, 1, 4'($urandom), 1'($urandom % 2), 0, 1, e, g);
        checks++;
        if (g !== 1'b1 || fifo_count !== 5'd3) begin
            errors++;
            $display("FAIL push_pop: rdy %b cnt %0d want 1 3", g, fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ($isunknown(rd_data) || rd_data !== m_head()) begin
                errors++;
                $display("FAIL drain%0d: got %b want %b", i, rd_data, m_head());
            end
            cyc(0, 0, 0, 0, 0, 1, e, g);
        end
    endtask

    task automatic test_saturate();
        bit e, g;
        cyc(1, 0, 0, 0, 0, 0, e, g);
        for (int i = 0; i < 40; i++)
            cyc(0, 1, 4'($urandom), 1'($urandom % 2), 0, 1, e, g);
        checks++;
        if (beat_count !== 5'd31 || signature !== m_sig || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL saturate: beats %0d sig %h cnt %0d want 31 %h 1",
                     beat_count, signature, fifo_count, m_sig);
        end
    endtask

    task automatic test_random();
        bit e, g;
        int n, sent, budget;
        for (int s = 0; s < 8; s++) begin
            cyc(1, 0, 0, 0, 0, 0, e, g);
            n = $urandom_range(1, 24);
            sent = 0;
            budget = 300;
            while (m_ph != 3 && budget > 0) begin
                budget--;
                golden_sig = ($urandom % 2) ? m_sig : 16'($urandom);
                if (m_ph == 1 && $urandom % 4 != 0) begin
                    cyc(0, 1, 4'($urandom), 1'($urandom % 2), sent == n - 1,
                        $urandom % 3 == 0, e, g);
                    if (e) sent++;
                end else begin
                    cyc(0, 0, 0, 0, 0, $urandom % 3 == 0, e, g);
                end
                checks++;
                if (g !== e || signature !== m_sig || fifo_count !== 5'(m_q.size())
                    || beat_count !== 5'(m_beats) || done !== m_done
                    || (m_done && mismatch !== m_mis) || rd_data !== m_head()
                    || rd_valid !== (m_q.size() > 0)) begin
                    errors++;
                    $display("FAIL rand%0d: rdy %b/%b sig %h/%h cnt %0d/%0d beats %0d/%0d done %b/%b mis %b/%b rd %b/%b",
                             s, g, e, signature, m_sig, fifo_count, m_q.size(),
                             beat_count, m_beats, done, m_done, mismatch, m_mis,
                             rd_data, m_head());
                end
            end
            checks++;
            if (budget == 0) begin
                errors++;
                $display("FAIL rand%0d_timeout: sweep did not finish", s);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit e, g;
        cyc(1, 0, 0, 0, 0, 0, e, g);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 4'($urandom), 1'($urandom % 2), 0, 0, e, g);
        #2;
        reset = 0;
        cap_valid = 1;
        #1;
        model_reset();
        checks++;
        if ({cap_ready, rd_valid, rd_data, fifo_count, beat_count,
             signature, done, mismatch} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0",
                     {cap_ready, rd_valid, rd_data, fifo_count, beat_count,
                      signature, done, mismatch});
        end
        @(posedge CK);
        #2;
        reset = 1;
        cap_valid = 0;
        cyc(0, 1, 4'b0110, 1, 0, 0, e, g);
        checks++;
        if (g !== 1'b0 || fifo_count !== 5'd0 || beat_count !== 5'd0
            || signature !== 16'h0) begin
            errors++;
            $display("FAIL idle_ignore: rdy %b cnt %0d beats %0d sig %h want 0",
                     g, fifo_count, beat_count, signature);
        end
    endtask

    initial begin
        test_reset();
        test_basic(16'h0002, 1'b0);
        test_readout();
        test_basic(16'h0003, 1'b1);
        test_restart();
        test_full();
        test_start_collision();
        test_push_pop();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
